// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared md_op encodings, FSM states and default cycle counts for mdu_ctrl
// MDU_DIV_EN selects whether div/divu count as real operations.
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Operations that occupy the unit for a multi-cycle busy period.
  function automatic logic is_long_op(input logic [3:0] op);
`ifdef MDU_DIV_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  // Operations that hold the requester for their accept cycle.
  function automatic logic is_md_op(input logic [3:0] op);
`ifdef MDU_DIV_EN
    return (op >= OP_MULT) && (op <= OP_MFLO);
`else
    return (op >= OP_MULT) && (op <= OP_MFLO) && (op != OP_DIV) && (op != OP_DIVU);
`endif
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational 64-bit multiply and (MDU_DIV_EN) divide datapath
// wr is low when the result must not be committed (divide by zero).
module mdu_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        wr,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic [31:0]        q_s;
  logic [31:0]        r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  // Dividing in 64 bits keeps -2^31 / -1 well defined (quotient wraps to 0x80000000).
  assign sa  = {{32{a[31]}}, a};
  assign sb  = {{32{b[31]}}, b};
  assign q_s = (b == 32'd0) ? 32'd0 : 32'(sa / sb);
  assign r_s = (b == 32'd0) ? 32'd0 : 32'(sa % sb);
  assign q_u = (b == 32'd0) ? 32'd0 : a / b;
  assign r_u = (b == 32'd0) ? 32'd0 : a % b;
`endif

  always_comb begin
    wr = 1'b0;
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      OP_MULT: begin
        wr = 1'b1;
        hi = prod_s[63:32];
        lo = prod_s[31:0];
      end
      OP_MULTU: begin
        wr = 1'b1;
        hi = prod_u[63:32];
        lo = prod_u[31:0];
      end
`ifdef MDU_DIV_EN
      OP_DIV: begin
        wr = (b != 32'd0);
        hi = r_s;
        lo = q_s;
      end
      OP_DIVU: begin
        wr = (b != 32'd0);
        hi = r_u;
        lo = q_u;
      end
`endif
      default: begin
        wr = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - HI/LO multiply/divide control: FSM, busy down-counter, HI/LO registers
// Define MDU_DIV_EN to compile in div/divu; otherwise they behave as no-ops.
module mdu_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        cancel,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
`ifdef MDU_DIV_EN
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
`endif

  md_state_e   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]  op_q, op_next;
  logic [31:0] a_q, a_next;
  logic [31:0] b_q, b_next;
  logic [31:0] hi_next, lo_next;
  logic        accept;
  logic        res_wr;
  logic [31:0] res_hi, res_lo;

  // Operands are latched so upstream forwarding may change during RUN.
  mdu_arith u_arith (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .wr (res_wr),
    .hi (res_hi),
    .lo (res_lo)
  );

  assign accept = start && !cancel && (state == ST_IDLE);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    op_next    = op_q;
    a_next     = a_q;
    b_next     = b_q;
    hi_next    = hi;
    lo_next    = lo;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_long_op(md_op)) begin
            op_next    = md_op;
            a_next     = rs_data;
            b_next     = rt_data;
            state_next = ST_RUN;
`ifdef MDU_DIV_EN
            cnt_next   = ((md_op == OP_MULT) || (md_op == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
`else
            cnt_next   = MULT_LOAD;
`endif
          end else if (md_op == OP_MTHI) begin
            hi_next = rs_data;
          end else if (md_op == OP_MTLO) begin
            lo_next = rs_data;
          end
        end
      end
      ST_RUN: begin
        if (cnt == CNT_ONE) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          if (res_wr) begin
            hi_next = res_hi;
            lo_next = res_lo;
          end
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= OP_NONE;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      op_q  <= op_next;
      a_q   <= a_next;
      b_q   <= b_next;
      hi    <= hi_next;
      lo    <= lo_next;
    end
  end

  assign busy  = (state == ST_RUN);
  assign stall = busy || (start && is_md_op(md_op) && !cancel);

  always_comb begin
    md_out = 32'd0;
    if (md_op == OP_MFHI) md_out = hi;
    else if (md_op == OP_MFLO) md_out = lo;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl: vector table, corner sequences, random vs model
// Expectations follow MDU_DIV_EN when the bench is compiled with it.
module tb_mdu_ctrl;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        cancel;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .cancel  (cancel),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo),
    .md_out  (md_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        cancel;
    logic        exp_stall;
    int          exp_cyc;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request: present for one cycle, then count busy cycles (bounded).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic c, output logic st, output int n);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b; cancel = c;
    #1 st = stall;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0; cancel = 1'b0;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  // Reference: architectural HI/LO effect of an accepted op, in plain 64-bit arithmetic.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic c, output logic exp_st, output int exp_n);
    longint sa, sb, q, r;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    exp_st = 1'b0;
    exp_n  = 0;
    if (c) return;
    case (op)
      4'd1: begin q = sa * sb; m_hi = q[63:32]; m_lo = q[31:0]; exp_st = 1; exp_n = 5; end
      4'd2: begin pu = {32'd0, a} * {32'd0, b}; m_hi = pu[63:32]; m_lo = pu[31:0]; exp_st = 1; exp_n = 5; end
      4'd3, 4'd4: if (DIV_EN) begin
        exp_st = 1; exp_n = 10;
        if (b != 0) begin
          if (op == 4'd4) begin sa = longint'({32'd0, a}); sb = longint'({32'd0, b}); end
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      4'd5: begin m_hi = a; exp_st = 1; end
      4'd6: begin m_lo = a; exp_st = 1; end
      4'd7, 4'd8: exp_st = 1;
      default: ;
    endcase
  endtask

  initial begin
    logic st;
    int   n;
    logic est;
    int   en;
    logic [3:0] rop;
    logic [31:0] ra, rb;
    logic rc;

    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1, 5, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1, 5, 32'h00000002, 32'hFFFFFFFA};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, DIV_EN, DIV_EN ? 10 : 0,
                DIV_EN ? 32'hFFFFFFFF : 32'h00000002, DIV_EN ? 32'hFFFFFFFD : 32'hFFFFFFFA};
    vecs[3] = '{4'd3, 32'hFFFFFFF9, 32'd0, 1'b0, DIV_EN, DIV_EN ? 10 : 0,
                DIV_EN ? 32'hFFFFFFFF : 32'h00000002, DIV_EN ? 32'hFFFFFFFD : 32'hFFFFFFFA};
    vecs[4] = '{4'd5, 32'h12345678, 32'd0, 1'b0, 1'b1, 0,
                32'h12345678, DIV_EN ? 32'hFFFFFFFD : 32'hFFFFFFFA};
    vecs[5] = '{4'd6, 32'hCAFEF00D, 32'd0, 1'b0, 1'b1, 0, 32'h12345678, 32'hCAFEF00D};
    vecs[6] = '{4'd1, 32'd7, 32'd7, 1'b1, 1'b0, 0, 32'h12345678, 32'hCAFEF00D};
    vecs[7] = '{4'd12, 32'd7, 32'd7, 1'b0, 1'b0, 0, 32'h12345678, 32'hCAFEF00D};
    vecs[8] = '{4'd4, 32'd100, 32'd7, 1'b0, DIV_EN, DIV_EN ? 10 : 0,
                DIV_EN ? 32'd2 : 32'h12345678, DIV_EN ? 32'd14 : 32'hCAFEF00D};
    vecs[9] = '{4'd1, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 5, 32'h40000000, 32'h00000000};

    reset_n = 1'b0; start = 1'b0; cancel = 1'b0; md_op = 4'd0; rs_data = 32'd0; rt_data = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].cancel, st, n);
      check($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d_busy_cycles", i), n, vecs[i].exp_cyc);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end
    m_hi = hi; m_lo = lo;

    // mthi then mfhi with no start: value forwarded, no stall after accept
    @(negedge clk);
    start = 1'b1; md_op = 4'd5; rs_data = 32'h12345678;
    @(negedge clk);
    start = 1'b0; md_op = 4'd7;
    #1;
    check("mfhi_md_out", md_out, 32'h12345678);
    check("mfhi_stall", 32'(stall), 32'd0);
    @(negedge clk);
    md_op = 4'd8;
    #1 check("mflo_md_out", md_out, m_lo);
    @(negedge clk);
    md_op = 4'd0;
    #1 check("none_md_out", md_out, 32'd0);
    m_hi = 32'h12345678;

    // second start during RUN is ignored; md_out shows pre-operation LO
    @(negedge clk);
    start = 1'b1; md_op = 4'd1; rs_data = 32'd3; rt_data = 32'd4;
    @(negedge clk);
    n = 1;
    rs_data = 32'd5; rt_data = 32'd6;
    #1 check("run_restart_stall", 32'(stall), 32'd1);
    @(negedge clk);
    n++;
    start = 1'b0; md_op = 4'd8;
    #1 check("run_md_out_old_lo", md_out, m_lo);
    @(negedge clk);
    md_op = 4'd0;
    for (int k = 0; k < 64; k++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    check("run_restart_cycles", n, 5);
    check("run_restart_hi", hi, 32'd0);
    check("run_restart_lo", lo, 32'd12);

    // reset on the third busy cycle aborts without a write
    @(negedge clk);
    start = 1'b1; md_op = 4'd1; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_3rd", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (8) @(negedge clk);
    check("abort_hi_later", hi, 32'd0);
    check("abort_lo_later", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 6))
        0: rop = 4'd1;
        1: rop = 4'd2;
        2: rop = 4'd3;
        3: rop = 4'd4;
        4: rop = 4'd5;
        5: rop = 4'd6;
        default: rop = 4'($urandom_range(9, 15));
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      rc = ($urandom_range(0, 7) == 0);
      run_op(rop, ra, rb, rc, st, n);
      model_op(rop, ra, rb, rc, est, en);
      check($sformatf("rnd%0d_op%0d_stall", i, rop), 32'(st), 32'(est));
      check($sformatf("rnd%0d_op%0d_cycles", i, rop), n, en);
      check($sformatf("rnd%0d_op%0d_hi", i, rop), hi, m_hi);
      check($sformatf("rnd%0d_op%0d_lo", i, rop), lo, m_lo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL provide port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset_n, input, 1: reset; synchronous, active-low.
REQ-005 SHALL provide port start, input, 1: the E-stage instruction presents md_op this cycle.
REQ-006 SHALL provide port cancel, input, 1: exception/interrupt flush; suppresses a same-cycle start.
REQ-007 SHALL provide port md_op, input, 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
REQ-008 SHALL provide port rs_data, input, 32: forwarded rs operand.
REQ-009 SHALL provide port rt_data, input, 32: forwarded rt operand.
REQ-010 SHALL provide port busy, output, 1: registered; a multi-cycle operation is in flight.
REQ-011 SHALL provide port stall, output, 1: combinational; busy OR (start AND md_op in 1..8 AND NOT cancel).
REQ-012 SHALL provide port hi, output, 32: registered HI.
REQ-013 SHALL provide port lo, output, 32: registered LO.
REQ-014 SHALL provide port md_out, output, 32: combinational; hi for mfhi, lo for mflo, else 0.

Function
REQ-015 SHALL implement states IDLE and RUN; busy = (state == RUN).
REQ-016 SHALL accept an operation only when start=1, cancel=0, state=IDLE ("accept").
REQ-017 SHALL, on accepting mult/multu/div/divu at edge T, latch the operands, load the down-counter with MULT_CYCLES or DIV_CYCLES, and enter RUN; busy is high for exactly that many cycles after T.
REQ-018 SHALL, at the edge where the counter is 1, write hi/lo, clear the counter and return to IDLE; the new hi/lo are visible in the cycle after the last busy cycle.
REQ-019 SHALL compute mult as the signed 64-bit product and multu as the unsigned 64-bit product, with hi = bits 63:32 and lo = bits 31:0.
REQ-020 SHALL compute div/divu as lo = quotient and hi = remainder, signed truncated toward zero for div; the remainder takes the sign of the dividend.
REQ-021 SHALL leave hi/lo unchanged when the divisor is 0, while still running the full DIV_CYCLES busy period.
REQ-022 SHALL, on accepting mthi or mtlo, write rs_data to hi or lo at that edge, with no RUN entry.
REQ-023 SHALL ignore start while in RUN; stall holds the requester upstream.
REQ-024 SHALL not abort an in-flight operation on cancel; cancel affects only a same-cycle start.
REQ-025 SHALL keep hi/lo stable during RUN; md_out during RUN reflects the pre-operation values.
REQ-026 SHALL treat none/invalid md_op with start=1 as a no-op and not assert stall.

Reset
REQ-027 SHALL, when reset_n=0 at an edge, set state=IDLE, counter=0, hi=0, lo=0 and busy=0, aborting any in-flight operation without writing hi/lo.
REQ-028 SHALL give reset priority over start and over completion in the same cycle.

Configuration
REQ-029 SHALL use the macro MDU_DIV_EN to compile the divide path in or out.
REQ-030 SHALL, with MDU_DIV_EN defined, behave as REQ-017 to REQ-021 for div/divu.
REQ-031 SHALL, without MDU_DIV_EN, treat div/divu as no-ops: no RUN entry, no stall, hi/lo unchanged, and no divider logic synthesised.

Structure
REQ-032 SHALL place the md_op encodings, the state encoding and the default cycle constants in shared package md_pkg.
REQ-033 SHALL place the 64-bit multiply/divide arithmetic in one combinational sub-module mdu_arith; mdu_ctrl holds the FSM, the counter and the hi/lo registers.

Verification
REQ-034 SHALL cover mult, rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 SHALL cover multu, same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-036 SHALL cover div, rs=-7, rt=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also div by 0 -> busy 10 cycles, hi/lo unchanged.
REQ-037 SHALL cover mthi rs=0x12345678, then mfhi next cycle -> md_out=0x12345678, stall never set after the accept cycle.
REQ-038 SHALL cover start=1 with cancel=1 on mult -> no busy, hi/lo unchanged. Also a second start during RUN -> ignored, stall=1.
REQ-039 SHALL cover reset_n=0 on the 3rd busy cycle of mult -> next cycle busy=0, hi=lo=0.
